gray_code_counter: RTL and testbench
====================================

Name: gray_code_counter

Overview:
- Upstream stage for gray_code_to_binary_convertor.
- Maintains an N-bit binary count and presents it as a registered Gray-coded value, so exactly one output bit changes per step.
- Supports up/down counting, synchronous clear and load, wrap/saturate modes and a one-cycle wrap indication.
- gray_value drives the converter's gray_value input directly.

Parameters:
N, 4, count width in bits (N >= 2)
SATURATE, 0, 0 = wrap around at limits; 1 = hold at limit and raise at_limit

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of count to 0
load  input  1  synchronous load of load_value
load_value  input  N  binary value to load
en  input  1  count enable (one step per cycle while high)
up_dn  input  1  1 = increment, 0 = decrement
gray_value  output  N  registered Gray code of current count
wrap  output  1  one-cycle pulse: the last count step wrapped
at_limit  output  1  count equals terminal value for current direction (SATURATE=1 only, else 0)

Behaviour:
- One clock. Reset is asynchronous and active-low on rstn.
- On rstn low:
  - internal binary count = 0
  - gray_value = 0, wrap = 0, at_limit = 0
  - takes effect immediately, including mid-operation
- Per-edge priority: clear > load > en > hold.
  - clear: count <= 0; wrap <= 0.
  - load: count <= load_value; wrap <= 0. up_dn and en are ignored that cycle.
  - en && up_dn: count <= count+1.
    - At 2^N-1 with SATURATE=0: count <= 0 and wrap <= 1.
    - At 2^N-1 with SATURATE=1: count holds and wrap <= 0.
  - en && !up_dn: count <= count-1.
    - At 0 with SATURATE=0: count <= 2^N-1 and wrap <= 1.
    - At 0 with SATURATE=1: count holds.
  - Otherwise: count holds; wrap <= 0.
- wrap is a single-cycle pulse, high only in the cycle following a wrapping edge.
  - Consecutive wraps are possible: N=2, en held, counting continuously.
- gray_value:
  - Registered on the same edge as count: gray_value <= next_count ^ (next_count >> 1).
  - Zero cycles of latency relative to count; one cycle after the en/load/clear sample.
  - Never derived combinationally at the output.
- at_limit is registered and reflects the post-edge count and post-edge up_dn:
  - at_limit = SATURATE && ((up_dn && count == 2^N-1) || (!up_dn && count == 0)).
  - Direction changes update it on the next edge.
- Single-bit-change guarantee: between consecutive en-driven steps, gray_value differs by exactly one bit, including across wrap. load and clear may change multiple bits.
- Arithmetic is modulo 2^N. No internal state other than count, wrap and at_limit registers.
- X on inputs while rstn low must not propagate.

Test Plan:
- N=4, SATURATE=0, reset then en=1, up_dn=1 for 16 cycles.
  - gray_value sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - wrap=1 only in the cycle after the 1000->0000 edge.
  - Every step has Hamming distance 1.
- After reset, en=1, up_dn=0, one cycle -> gray_value=1000 (count 15), wrap=1 for one cycle. Next cycle -> 1001 (count 14), wrap=0.
- load=1, load_value=5 (with en=1, up_dn=1) -> gray_value=0111 next cycle. Then one en step up -> 0101 (count 6).
- clear=1 and load=1 (load_value=9) in the same cycle -> gray_value=0000, wrap=0.
- SATURATE=1: load 14, en=1, up_dn=1 for 3 cycles.
  - gray_value goes 1001 -> 1000 -> 1000 -> 1000.
  - at_limit=1 from count 15 onward; wrap stays 0.
  - Switching up_dn=0 -> at_limit=0 and next step gives 1001.
- Reset mid-count: at count 10 (gray 1111), pulse rstn low asynchronously between edges.
  - gray_value, wrap and at_limit go 0 immediately.
  - After release, counting resumes from 0000 -> 0001.

Source files
------------

// File: rtl/gray_code_counter_if.sv
// Control and result bundle for gray_code_counter.
// The bench or upstream logic is the master; the counter is the slave.
interface gray_code_counter_if #(
    parameter int N = 4
) ();
    logic         clear;
    logic         load;
    logic [N-1:0] load_value;
    logic         en;
    logic         up_dn;
    logic [N-1:0] gray_value;
    logic         wrap;
    logic         at_limit;

    modport master (
        output clear, load, load_value, en, up_dn,
        input  gray_value, wrap, at_limit
    );

    modport slave (
        input  clear, load, load_value, en, up_dn,
        output gray_value, wrap, at_limit
    );
endinterface

// File: rtl/gray_code_counter.sv
// N-bit up/down binary counter presented as a registered Gray code.
// Feeds gray_code_to_binary_convertor; wrap/saturate selected by SATURATE.
module gray_code_counter #(
    parameter int N        = 4,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    gray_code_counter_if.slave   bus
);

    localparam logic [N-1:0] MAXV = {N{1'b1}};
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam bit           SAT  = (SATURATE != 0);

    logic [N-1:0] count;
    logic [N-1:0] countNext;
    logic         wrapNext;
    logic         atLimitNext;

    // Next count and wrap flag; priority is clear, then load, then enabled step.
    always_comb begin
        countNext = count;
        wrapNext  = 1'b0;
        if (bus.clear) begin
            countNext = '0;
        end else if (bus.load) begin
            countNext = bus.load_value;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (count == MAXV) begin
                    if (!SAT) begin
                        countNext = '0;
                        wrapNext  = 1'b1;
                    end
                end else begin
                    countNext = count + ONE;
                end
            end else begin
                if (count == '0) begin
                    if (!SAT) begin
                        countNext = MAXV;
                        wrapNext  = 1'b1;
                    end
                end else begin
                    countNext = count - ONE;
                end
            end
        end
    end

    // at_limit looks at the count being registered and the direction sampled now.
    always_comb begin
        atLimitNext = SAT && (bus.up_dn ? (countNext == MAXV) : (countNext == '0));
    end

    // Gray output is registered alongside the count so it carries no glitches.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count          <= '0;
            bus.gray_value <= '0;
            bus.wrap       <= 1'b0;
            bus.at_limit   <= 1'b0;
        end else begin
            count          <= countNext;
            bus.gray_value <= countNext ^ (countNext >> 1);
            bus.wrap       <= wrapNext;
            bus.at_limit   <= atLimitNext;
        end
    end

endmodule

// File: tb/tb_gray_code_counter.sv
// Scoreboard bench: three counters (N=4 wrap, N=4 saturate, N=2 wrap) share
// one stimulus stream and are checked against a table-driven reference model.
module tb_gray_code_counter;

    typedef struct packed {
        logic [2:0][3:0] g;
        logic [2:0]      w;
        logic [2:0]      a;
    } exp_t;

    logic clk;
    logic rstn;
    int   testsRun;
    int   testsFailed;

    gray_code_counter_if #(.N(4)) ifc0 ();
    gray_code_counter_if #(.N(4)) ifc1 ();
    gray_code_counter_if #(.N(2)) ifc2 ();

    gray_code_counter #(.N(4), .SATURATE(0)) dut0 (.clk(clk), .rstn(rstn), .bus(ifc0));
    gray_code_counter #(.N(4), .SATURATE(1)) dut1 (.clk(clk), .rstn(rstn), .bus(ifc1));
    gray_code_counter #(.N(2), .SATURATE(0)) dut2 (.clk(clk), .rstn(rstn), .bus(ifc2));

    exp_t expQ[$];
    int   gt4[$];
    int   gt2[$];
    int   cnt[3];
    int   nbits[3] = '{4, 4, 2};
    bit   sat[3]   = '{1'b0, 1'b1, 1'b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reflected-binary construction, independent of any xor formula.
    task automatic buildGray(input int bits, output int tab[$]);
        int len;
        tab = {0};
        for (int b = 0; b < bits; b++) begin
            len = tab.size();
            for (int i = len - 1; i >= 0; i--) tab.push_back(tab[i] | (1 << b));
        end
    endtask

    task automatic modelStep(input bit c, input bit l, input int lv, input bit e, input bit u);
        exp_t x;
        int   maxv;
        bit   wr;
        for (int k = 0; k < 3; k++) begin
            maxv = (1 << nbits[k]) - 1;
            wr   = 1'b0;
            if (c) cnt[k] = 0;
            else if (l) cnt[k] = lv & maxv;
            else if (e && u) begin
                if (cnt[k] < maxv) cnt[k]++;
                else if (!sat[k]) begin cnt[k] = 0; wr = 1'b1; end
            end else if (e && !u) begin
                if (cnt[k] > 0) cnt[k]--;
                else if (!sat[k]) begin cnt[k] = maxv; wr = 1'b1; end
            end
            x.g[k] = 4'((nbits[k] == 4) ? gt4[cnt[k]] : gt2[cnt[k]]);
            x.w[k] = wr;
            x.a[k] = sat[k] && ((u && cnt[k] == maxv) || (!u && cnt[k] == 0));
        end
        expQ.push_back(x);
    endtask

    task automatic driveInputs(input logic c, input logic l, input logic [3:0] lv,
                               input logic e, input logic u);
        ifc0.clear = c; ifc1.clear = c; ifc2.clear = c;
        ifc0.load  = l; ifc1.load  = l; ifc2.load  = l;
        ifc0.load_value = lv; ifc1.load_value = lv; ifc2.load_value = lv[1:0];
        ifc0.en    = e; ifc1.en    = e; ifc2.en    = e;
        ifc0.up_dn = u; ifc1.up_dn = u; ifc2.up_dn = u;
    endtask

    task automatic applyStimulus(input bit c, input bit l, input int lv, input bit e, input bit u);
        driveInputs(c, l, 4'(lv), e, u);
        @(posedge clk);
        modelStep(c, l, lv, e, u);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".gray0"}, int'(ifc0.gray_value), 0);
        checkOutput({tag, ".gray1"}, int'(ifc1.gray_value), 0);
        checkOutput({tag, ".gray2"}, int'(ifc2.gray_value), 0);
        checkOutput({tag, ".wrap0"}, int'(ifc0.wrap), 0);
        checkOutput({tag, ".wrap2"}, int'(ifc2.wrap), 0);
        checkOutput({tag, ".atlim1"}, int'(ifc1.at_limit), 0);
    endtask

    // Reset lands between edges, after the monitor has drained the pending entry.
    task automatic midReset();
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checkAllZero("asyncReset");
        driveInputs('x, 'x, 'x, 'x, 'x);
        @(posedge clk);
        #1;
        checkAllZero("heldReset");
        @(negedge clk);
        #1;
        driveInputs(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) cnt[k] = 0;
    endtask

    always @(negedge clk) begin
        exp_t       x;
        logic [3:0] ag[3];
        logic [2:0] aw;
        logic [2:0] aa;
        if (expQ.size() > 0) begin
            x     = expQ.pop_front();
            ag[0] = ifc0.gray_value;
            ag[1] = ifc1.gray_value;
            ag[2] = {2'b00, ifc2.gray_value};
            aw    = {ifc2.wrap, ifc1.wrap, ifc0.wrap};
            aa    = {ifc2.at_limit, ifc1.at_limit, ifc0.at_limit};
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("gray%0d", k), int'(ag[k]), int'(x.g[k]));
                checkOutput($sformatf("wrap%0d", k), int'(aw[k]), int'(x.w[k]));
                checkOutput($sformatf("atLimit%0d", k), int'(aa[k]), int'(x.a[k]));
            end
        end
    end

    initial begin
        bit u;
        bit c;
        bit l;
        bit e;
        testsRun    = 0;
        testsFailed = 0;
        buildGray(4, gt4);
        buildGray(2, gt2);
        for (int k = 0; k < 3; k++) cnt[k] = 0;

        rstn = 1'b0;
        driveInputs('x, 'x, 'x, 'x, 'x);
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("powerOnReset");
        driveInputs(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #2;
        rstn = 1'b1;

        // Full up sweep through the wrap, then a fresh down-wrap from zero.
        repeat (16) applyStimulus(0, 0, 0, 1, 1);
        midReset();
        repeat (2) applyStimulus(0, 0, 0, 1, 0);

        // Load beats en, clear beats load.
        applyStimulus(0, 1, 5, 1, 1);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(1, 1, 9, 1, 1);

        // Saturation at top, then turn around.
        applyStimulus(0, 1, 14, 0, 1);
        repeat (3) applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);

        // Saturation at bottom.
        applyStimulus(0, 1, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);

        // Reset from count 10, then resume counting.
        applyStimulus(0, 1, 10, 0, 1);
        midReset();
        applyStimulus(0, 0, 0, 1, 1);

        u = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) u = ~u;
            c = ($urandom_range(0, 24) == 0);
            l = ($urandom_range(0, 11) == 0);
            e = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 99) == 0) midReset();
            applyStimulus(c, l, int'($urandom_range(0, 15)), e, u);
        end

        @(negedge clk);
        #1;
        checkOutput("queueDrained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
